alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit ALU between two requesters, for example the main datapath and a branch/address helper. Each requester presents operands and an opcode through a valid/ready handshake. The block grants one request at a time, drives the ALU for ALU_LAT cycles and captures result and zero. It returns them on that requester's response channel, held until acknowledged.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/alu_share_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing arbiter:
//   - ALU opcode constants
//   - op_legal(): returns 1 for opcodes the ALU implements
//   - state_t   : sequencer state encoding (IDLE / ISSUE / RESP)
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Opcodes 011, 100 and 101 have no ALU function behind them.
   function automatic logic op_legal(input logic [2:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
         default:                                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way combinational arbiter. Grants the sole valid requester, or the
// requester named by prio when both are valid. No grant while enable=0.
// Ports:
//   valid  [1:0] in   request lines
//   prio         in   index of the requester that wins a tie
//   enable       in   grants allowed this cycle
//   grant  [1:0] out  one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arbiter2
   import alu_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       prio,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         grant[0] = valid[0] & (~valid[1] | ~prio);
         grant[1] = valid[1] & (~valid[0] |  prio);
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between two requesters. One operation at a time is
// accepted in IDLE (round-robin on ties), issued to the ALU for ALU_LAT
// cycles, and its result/zero captured into the owner's response registers,
// which are presented until the owner acknowledges. Illegal opcodes skip
// the ALU and answer directly with err=1.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op          request channel of requester N
//   rspN_valid/ready/result/zero/err response channel of requester N
//   alu_A, alu_B, alu_control        drive to the shared ALU
//   alu_result, alu_zero             ALU outputs
//   busy                             high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp0_err,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic             rsp1_err,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   // Index of the final ISSUE cycle.
   localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_ctrl_q, alu_ctrl_d;

   logic [WIDTH-1:0] rsp_result_q [2];
   logic [WIDTH-1:0] rsp_result_d [2];
   logic [1:0]       rsp_zero_q, rsp_zero_d;
   logic [1:0]       rsp_err_q, rsp_err_d;

   logic [1:0]       grant;
   logic [1:0]       rsp_ready_vec;
   logic             accept;
   logic             acc_owner;
   logic [WIDTH-1:0] acc_a, acc_b;
   logic [2:0]       acc_op;
   logic             acc_legal;
   logic             capture;

   rr_arbiter2 u_arb (
      .valid  ({req1_valid, req0_valid}),
      .prio   (prio_q),
      .enable (state_q == IDLE),
      .grant  (grant)
   );

   assign req0_ready    = grant[0];
   assign req1_ready    = grant[1];
   assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

   // Grants are already qualified by valid, so any grant is an accept.
   assign accept    = |grant;
   assign acc_owner = grant[1];
   assign acc_a     = acc_owner ? req1_a  : req0_a;
   assign acc_b     = acc_owner ? req1_b  : req0_b;
   assign acc_op    = acc_owner ? req1_op : req0_op;
   assign acc_legal = op_legal(acc_op);

   // Sequencer next-state logic.
   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_ctrl_d = alu_ctrl_q;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = acc_owner;
               prio_d  = ~acc_owner;
               if (acc_legal) begin
                  // ALU drive only changes for ops that actually use it.
                  alu_a_d    = acc_a;
                  alu_b_d    = acc_b;
                  alu_ctrl_d = acc_op;
                  cnt_d      = 3'd0;
                  state_d    = ISSUE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         ISSUE: begin
            if (cnt_q == LAST_CNT) begin
               capture = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready_vec[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Response registers: loaded with an error answer on an illegal accept,
   // or with the ALU outputs on the capture edge.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rsp_result_d[i] = rsp_result_q[i];
      end
      rsp_zero_d = rsp_zero_q;
      rsp_err_d  = rsp_err_q;
      if (state_q == IDLE && accept && !acc_legal) begin
         rsp_result_d[acc_owner] = '0;
         rsp_zero_d[acc_owner]   = 1'b0;
         rsp_err_d[acc_owner]    = 1'b1;
      end else if (capture) begin
         rsp_result_d[owner_q] = alu_result;
         rsp_zero_d[owner_q]   = alu_zero;
         rsp_err_d[owner_q]    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         owner_q    <= 1'b0;
         cnt_q      <= 3'd0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= 3'b000;
         for (int i = 0; i < 2; i++) begin
            rsp_result_q[i] <= '0;
         end
         rsp_zero_q <= 2'b00;
         rsp_err_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_ctrl_q <= alu_ctrl_d;
         for (int i = 0; i < 2; i++) begin
            rsp_result_q[i] <= rsp_result_d[i];
         end
         rsp_zero_q <= rsp_zero_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign alu_A       = alu_a_q;
   assign alu_B       = alu_b_q;
   assign alu_control = alu_ctrl_q;
   assign busy        = (state_q != IDLE);

   assign rsp0_valid  = (state_q == RESP) && !owner_q;
   assign rsp1_valid  = (state_q == RESP) &&  owner_q;
   assign rsp0_result = rsp_result_q[0];
   assign rsp1_result = rsp_result_q[1];
   assign rsp0_zero   = rsp_zero_q[0];
   assign rsp1_zero   = rsp_zero_q[1];
   assign rsp0_err    = rsp_err_q[0];
   assign rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench. Instance a uses ALU_LAT=1 with a combinational ALU model;
// instance b uses ALU_LAT=3 with an ALU model whose result lags by 3 cycles.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

   logic clk;
   int   compared   = 0;
   int   mismatched = 0;

   // ---------------- instance a signals ----------------
   logic        a_reset;
   logic        a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
   logic [31:0] a_req0_a, a_req0_b, a_req1_a, a_req1_b;
   logic [2:0]  a_req0_op, a_req1_op;
   logic        a_rsp0_valid, a_rsp0_ready, a_rsp0_zero, a_rsp0_err;
   logic        a_rsp1_valid, a_rsp1_ready, a_rsp1_zero, a_rsp1_err;
   logic [31:0] a_rsp0_result, a_rsp1_result;
   logic [31:0] a_alu_A, a_alu_B, a_alu_result;
   logic [2:0]  a_alu_control;
   logic        a_alu_zero, a_busy;

   // ---------------- instance b signals ----------------
   logic        b_reset;
   logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
   logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
   logic [2:0]  b_req0_op, b_req1_op;
   logic        b_rsp0_valid, b_rsp0_ready, b_rsp0_zero, b_rsp0_err;
   logic        b_rsp1_valid, b_rsp1_ready, b_rsp1_zero, b_rsp1_err;
   logic [31:0] b_rsp0_result, b_rsp1_result;
   logic [31:0] b_alu_A, b_alu_B, b_alu_result;
   logic [2:0]  b_alu_control;
   logic        b_alu_zero, b_busy;

   alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut_a (
      .clk(clk), .reset(a_reset),
      .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
      .req0_a(a_req0_a), .req0_b(a_req0_b), .req0_op(a_req0_op),
      .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready),
      .rsp0_result(a_rsp0_result), .rsp0_zero(a_rsp0_zero), .rsp0_err(a_rsp0_err),
      .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
      .req1_a(a_req1_a), .req1_b(a_req1_b), .req1_op(a_req1_op),
      .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready),
      .rsp1_result(a_rsp1_result), .rsp1_zero(a_rsp1_zero), .rsp1_err(a_rsp1_err),
      .alu_A(a_alu_A), .alu_B(a_alu_B), .alu_control(a_alu_control),
      .alu_result(a_alu_result), .alu_zero(a_alu_zero), .busy(a_busy)
   );

   alu_share_arbiter #(.WIDTH(32), .ALU_LAT(3)) dut_b (
      .clk(clk), .reset(b_reset),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
      .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_op(b_req0_op),
      .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
      .rsp0_result(b_rsp0_result), .rsp0_zero(b_rsp0_zero), .rsp0_err(b_rsp0_err),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
      .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_op(b_req1_op),
      .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
      .rsp1_result(b_rsp1_result), .rsp1_zero(b_rsp1_zero), .rsp1_err(b_rsp1_err),
      .alu_A(b_alu_A), .alu_B(b_alu_B), .alu_control(b_alu_control),
      .alu_result(b_alu_result), .alu_zero(b_alu_zero), .busy(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] op);
      logic [31:0] r;
      case (op)
         3'b000:  r = x & y;
         3'b001:  r = x | y;
         3'b010:  r = x + y;
         3'b110:  r = x - y;
         3'b111:  r = {31'd0, ($signed(x) < $signed(y))};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Instance a: zero-latency ALU, sampled on the single ISSUE edge.
   always_comb begin
      a_alu_result = alu_f(a_alu_A, a_alu_B, a_alu_control);
      a_alu_zero   = (a_alu_result == 32'd0);
   end

   // Instance b: result visible two edges after the inputs, i.e. only in
   // the third ISSUE cycle.
   logic [31:0] b_pipe1 = 32'd0, b_pipe2 = 32'd0;
   always @(posedge clk) begin
      b_pipe1 <= alu_f(b_alu_A, b_alu_B, b_alu_control);
      b_pipe2 <= b_pipe1;
   end
   always_comb begin
      b_alu_result = b_pipe2;
      b_alu_zero   = (b_pipe2 == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   initial begin
      a_reset = 1'b1; b_reset = 1'b1;
      a_req0_valid = 0; a_req1_valid = 0; a_req0_a = 0; a_req0_b = 0; a_req0_op = 0;
      a_req1_a = 0; a_req1_b = 0; a_req1_op = 0; a_rsp0_ready = 0; a_rsp1_ready = 0;
      b_req0_valid = 0; b_req1_valid = 0; b_req0_a = 0; b_req0_b = 0; b_req0_op = 0;
      b_req1_a = 0; b_req1_b = 0; b_req1_op = 0; b_rsp0_ready = 0; b_rsp1_ready = 0;
      step(); step();
      a_reset = 1'b0; b_reset = 1'b0;
      settle();

      // ---- reset state ----
      chk("rst_busy",   32'(a_busy), 32'd0);
      chk("rst_rsp0v",  32'(a_rsp0_valid), 32'd0);
      chk("rst_rsp1v",  32'(a_rsp1_valid), 32'd0);
      chk("rst_result", a_rsp0_result, 32'd0);
      chk("rst_aluA",   a_alu_A, 32'd0);
      chk("rst_aluctl", 32'(a_alu_control), 32'd0);
      chk("rst_b_busy", 32'(b_busy), 32'd0);

      // ---- T1: req0 ADD, ALU_LAT=1 ----
      step();
      a_req0_valid = 1; a_req0_a = 32'h800C001C; a_req0_b = 32'h8008001C;
      a_req0_op = 3'b010; a_rsp0_ready = 1;
      settle();
      chk("t1_c0_ready", 32'(a_req0_ready), 32'd1);
      chk("t1_c0_busy",  32'(a_busy), 32'd0);
      step();
      a_req0_valid = 0;
      settle();
      chk("t1_c1_aluA",   a_alu_A, 32'h800C001C);
      chk("t1_c1_aluB",   a_alu_B, 32'h8008001C);
      chk("t1_c1_aluctl", 32'(a_alu_control), 32'h2);
      chk("t1_c1_busy",   32'(a_busy), 32'd1);
      chk("t1_c1_rsp0v",  32'(a_rsp0_valid), 32'd0);
      step(); settle();
      chk("t1_c2_rsp0v",  32'(a_rsp0_valid), 32'd1);
      chk("t1_c2_result", a_rsp0_result, 32'h00140038);
      chk("t1_c2_zero",   32'(a_rsp0_zero), 32'd0);
      chk("t1_c2_err",    32'(a_rsp0_err), 32'd0);
      chk("t1_c2_rsp1v",  32'(a_rsp1_valid), 32'd0);
      $display("txn T1 req0 ADD result=%h", a_rsp0_result);
      step(); settle();
      chk("t1_c3_busy",  32'(a_busy), 32'd0);
      chk("t1_c3_rsp0v", 32'(a_rsp0_valid), 32'd0);

      // ---- T2: simultaneous requests from reset ----
      a_reset = 1'b1;
      step();
      a_reset = 1'b0;
      a_req0_valid = 1; a_req0_a = 32'h8008001C; a_req0_b = 32'h2; a_req0_op = 3'b110;
      a_req1_valid = 1; a_req1_a = 32'h8008001C; a_req1_b = 32'h2; a_req1_op = 3'b001;
      a_rsp0_ready = 1; a_rsp1_ready = 1;
      settle();
      chk("t2_c0_r0", 32'(a_req0_ready), 32'd1);
      chk("t2_c0_r1", 32'(a_req1_ready), 32'd0);
      step();
      a_req0_valid = 0;
      settle();
      chk("t2_c1_r1", 32'(a_req1_ready), 32'd0);
      step(); settle();
      chk("t2_c2_rsp0v",  32'(a_rsp0_valid), 32'd1);
      chk("t2_c2_result", a_rsp0_result, 32'h8008001A);
      chk("t2_c2_rsp1v",  32'(a_rsp1_valid), 32'd0);
      $display("txn T2a req0 SUB result=%h", a_rsp0_result);
      step(); settle();
      chk("t2_c3_r1", 32'(a_req1_ready), 32'd1);
      step();
      a_req1_valid = 0;
      settle();
      step(); settle();
      chk("t2_c5_rsp1v",  32'(a_rsp1_valid), 32'd1);
      chk("t2_c5_result", a_rsp1_result, 32'h8008001E);
      chk("t2_c5_rsp0v",  32'(a_rsp0_valid), 32'd0);
      $display("txn T2b req1 OR result=%h", a_rsp1_result);
      step();
      a_req0_valid = 1; a_req1_valid = 1;
      settle();
      chk("t2_c6_r0", 32'(a_req0_ready), 32'd1);
      chk("t2_c6_r1", 32'(a_req1_ready), 32'd0);
      step();
      a_req0_valid = 0; a_req1_valid = 0;
      settle();
      step(); settle();
      chk("t2_c8_rsp0v", 32'(a_rsp0_valid), 32'd1);
      $display("txn T2c req0 granted on repeat pair");
      step(); settle();

      // ---- T3: req1 SUB to zero, response held 5 cycles ----
      a_req1_valid = 1; a_req1_a = 32'h8008001C; a_req1_b = 32'h8008001C; a_req1_op = 3'b110;
      a_rsp1_ready = 0; a_rsp0_ready = 0;
      settle();
      chk("t3_c0_r1", 32'(a_req1_ready), 32'd1);
      step();
      a_req1_valid = 0;
      a_req0_valid = 1; a_req0_a = 32'h1; a_req0_b = 32'h2; a_req0_op = 3'b101;
      settle();
      chk("t3_c1_r0", 32'(a_req0_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(); settle();
         chk($sformatf("t3_hold%0d_rsp1v", i), 32'(a_rsp1_valid), 32'd1);
         chk($sformatf("t3_hold%0d_res", i),   a_rsp1_result, 32'd0);
         chk($sformatf("t3_hold%0d_zero", i),  32'(a_rsp1_zero), 32'd1);
         chk($sformatf("t3_hold%0d_busy", i),  32'(a_busy), 32'd1);
         chk($sformatf("t3_hold%0d_r0", i),    32'(a_req0_ready), 32'd0);
         chk($sformatf("t3_hold%0d_rsp0v", i), 32'(a_rsp0_valid), 32'd0);
      end
      $display("txn T3 req1 SUB result=%h zero=%b", a_rsp1_result, a_rsp1_zero);
      a_rsp1_ready = 1;
      step();
      a_rsp1_ready = 0;
      settle();
      chk("t3_idle_rsp1v", 32'(a_rsp1_valid), 32'd0);
      chk("t3_idle_busy",  32'(a_busy), 32'd0);
      chk("t3_idle_r0",    32'(a_req0_ready), 32'd1);

      // ---- T4: req0 illegal opcode 101 accepted in the cycle above ----
      a_rsp0_ready = 1;
      step();
      a_req0_valid = 0;
      settle();
      chk("t4_rsp0v",   32'(a_rsp0_valid), 32'd1);
      chk("t4_err",     32'(a_rsp0_err), 32'd1);
      chk("t4_result",  a_rsp0_result, 32'd0);
      chk("t4_zero",    32'(a_rsp0_zero), 32'd0);
      chk("t4_aluA",    a_alu_A, 32'h8008001C);
      chk("t4_aluB",    a_alu_B, 32'h8008001C);
      chk("t4_aluctl",  32'(a_alu_control), 32'h6);
      $display("txn T4 req0 illegal op err=%b", a_rsp0_err);
      step(); settle();
      chk("t4_idle_busy", 32'(a_busy), 32'd0);

      // ---- T5: ALU_LAT=3 with delayed ALU ----
      b_req0_valid = 1; b_req0_a = 32'd5; b_req0_b = 32'd7; b_req0_op = 3'b010;
      b_rsp0_ready = 1;
      settle();
      chk("t5_c0_r0", 32'(b_req0_ready), 32'd1);
      step();
      b_req0_valid = 0;
      settle();
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("t5_c%0d_aluA", i),   b_alu_A, 32'd5);
         chk($sformatf("t5_c%0d_aluctl", i), 32'(b_alu_control), 32'h2);
         chk($sformatf("t5_c%0d_rsp0v", i),  32'(b_rsp0_valid), 32'd0);
         step(); settle();
      end
      chk("t5_c4_rsp0v",  32'(b_rsp0_valid), 32'd1);
      chk("t5_c4_result", b_rsp0_result, 32'd12);
      $display("txn T5 req0 ADD lat3 result=%h", b_rsp0_result);
      step(); settle();
      chk("t5_c5_busy", 32'(b_busy), 32'd0);

      // Second op from req1, aborted by reset in its second ISSUE cycle.
      b_req1_valid = 1; b_req1_a = 32'hF0; b_req1_b = 32'h3C; b_req1_op = 3'b000;
      b_rsp1_ready = 1;
      settle();
      chk("t5_abort_r1", 32'(b_req1_ready), 32'd1);
      step();
      b_req1_valid = 0;
      settle();
      step();
      b_reset = 1'b1;
      settle();
      chk("t5_abort_busy_pre", 32'(b_busy), 32'd1);
      step();
      b_reset = 1'b0;
      settle();
      chk("t5_abort_busy",  32'(b_busy), 32'd0);
      chk("t5_abort_rsp1v", 32'(b_rsp1_valid), 32'd0);
      chk("t5_abort_rsp0v", 32'(b_rsp0_valid), 32'd0);
      chk("t5_abort_aluA",  b_alu_A, 32'd0);
      b_req0_valid = 1; b_req1_valid = 1;
      settle();
      chk("t5_prio_r0", 32'(b_req0_ready), 32'd1);
      chk("t5_prio_r1", 32'(b_req1_ready), 32'd0);
      $display("txn T5 reset abort, prio back to req0");
      b_req0_valid = 0; b_req1_valid = 0;
      for (int i = 0; i < 4; i++) begin
         step(); settle();
         chk($sformatf("t5_post%0d_rsp1v", i), 32'(b_rsp1_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
